route_dispatch4_sync: RTL and testbench

// - Clocked front end for the 4-way no-data selector stage. Queues 2-bit destination tags and

---
 rtl/route_dispatch_pkg.sv | 21 ++
 rtl/route_dispatch4_sync_if.sv | 27 ++
 rtl/tag_fifo_sync.sv | 62 ++++++
 rtl/route_dispatch4_sync.sv | 118 +++++++++++
 tb/tb_route_dispatch4_sync.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/route_dispatch_pkg.sv
// Shared types and helpers for the 4-way tag dispatcher in front of the click-style selector stage.
package route_dispatch_pkg;

  localparam int unsigned DEST_W    = 2;
  localparam int unsigned NUM_PORTS = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    FIRE      = 2'd2,
    WAIT_FREE = 2'd3
  } dispatchState_e;

  // Destination index to one-hot select.
  function automatic logic [NUM_PORTS-1:0] dest2onehot(input logic [DEST_W-1:0] dest);
    logic [NUM_PORTS-1:0] one;
    one = NUM_PORTS'(1);
    return one << dest;
  endfunction

endpackage

// File: rtl/route_dispatch4_sync_if.sv
// Scheduler-side valid/ready and selector-side drive/free signals of the dispatcher.
interface route_dispatch4_sync_if;
  import route_dispatch_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DEST_W-1:0]    in_dest;
  logic [NUM_PORTS-1:0] o_select;
  logic                 o_drive;
  logic                 i_free;
  logic                 o_busy;
  logic                 o_timeout;
  logic                 i_clr_timeout;

  // Dispatcher side.
  modport slave (
    input  in_valid, in_dest, i_free, i_clr_timeout,
    output in_ready, o_select, o_drive, o_busy, o_timeout
  );

  // Scheduler / selector-stage side.
  modport master (
    output in_valid, in_dest, i_free, i_clr_timeout,
    input  in_ready, o_select, o_drive, o_busy, o_timeout
  );

endinterface

// File: rtl/tag_fifo_sync.sv
// Small synchronous FIFO for short tags; full/empty are registered alongside the occupancy count.
module tag_fifo_sync #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             popData,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] nextCount;
  logic             doPush;
  logic             doPop;

  // A push offered while full is not a push, even if a pop happens in the same cycle.
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  always_comb begin
    nextCount = count;
    if (doPush && !doPop) begin
      nextCount = count + CNT_W'(1);
    end else if (doPop && !doPush) begin
      nextCount = count - CNT_W'(1);
    end
  end

  // Pointers are exactly log2(DEPTH) wide and wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= nextCount;
      full  <= (nextCount == CNT_W'(DEPTH));
      empty <= (nextCount == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/route_dispatch4_sync.sv
// Queues destination tags and issues one drive pulse per tag with a stable one-hot select,
// waiting for the selector stage's asynchronous free return before issuing the next one.
module route_dispatch4_sync
  import route_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  route_dispatch4_sync_if.slave bus
);

  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FCNT_W  = $clog2(DEPTH + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  dispatchState_e       state;
  logic [NUM_PORTS-1:0] selectQ;
  logic                 driveQ;
  logic                 timeoutQ;
  logic [CNT_W-1:0]     waitCnt;

  logic                 fifoPop;
  logic [DEST_W-1:0]    fifoHead;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic [FCNT_W-1:0]    fifoCount;

  logic [SYNC_STAGES-1:0] freeSync;
  logic                   freePrev;
  logic                   freeRise;

  // The head is consumed in the same cycle the FSM leaves IDLE.
  assign fifoPop = (state == IDLE);

  tag_fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (DEST_W)
  ) u_tagFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.in_valid),
    .pushData (bus.in_dest),
    .pop      (fifoPop),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Free return crosses in asynchronously; only its rising edge means anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      freeSync <= '0;
      freePrev <= 1'b0;
    end else begin
      freeSync <= {freeSync[SYNC_STAGES-2:0], bus.i_free};
      freePrev <= freeSync[SYNC_STAGES-1];
    end
  end

  assign freeRise = freeSync[SYNC_STAGES-1] & ~freePrev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      selectQ  <= '0;
      driveQ   <= 1'b0;
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      driveQ <= 1'b0;
      // A timeout in the same cycle overrides this clear further down.
      if (bus.i_clr_timeout) timeoutQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            selectQ <= dest2onehot(fifoHead);
            state   <= SETUP;
          end
        end
        SETUP: begin
          driveQ <= 1'b1;
          state  <= FIRE;
        end
        FIRE: begin
          waitCnt <= '0;
          state   <= WAIT_FREE;
        end
        WAIT_FREE: begin
          if (freeRise) begin
            selectQ <= '0;
            state   <= IDLE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
            // An unanswered token is dropped rather than re-driven.
            if (TIMEOUT_EN && (waitCnt == TIMEOUT_LAST)) begin
              timeoutQ <= 1'b1;
              selectQ  <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ~fifoFull;
  assign bus.o_select  = selectQ;
  assign bus.o_drive   = driveQ;
  assign bus.o_timeout = timeoutQ;
  assign bus.o_busy    = (state != IDLE) | (fifoCount != '0);

endmodule

// File: tb/tb_route_dispatch4_sync.sv
// Directed and randomized checks of the tag dispatcher with a small selector-stage responder.
module tb_route_dispatch4_sync;
  import route_dispatch_pkg::*;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 8;
  localparam int          NUM_RANDOM  = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  route_dispatch4_sync_if bus();

  route_dispatch4_sync #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [3:0] drvQ[$];
  int         oneHotErr = 0;
  int         stabErr   = 0;
  logic [3:0] prevSel   = '0;

  // Records every drive with its select and watches the select invariants all run long.
  always @(negedge clk) begin
    if (rst) begin
      prevSel = '0;
    end else begin
      if (bus.o_drive) begin
        drvQ.push_back(bus.o_select);
        if (bus.o_select == 4'b0000) stabErr++;
      end
      if ((bus.o_select & (bus.o_select - 4'd1)) != 4'd0) oneHotErr++;
      if (prevSel != 4'd0 && bus.o_select != 4'd0 && bus.o_select != prevSel) stabErr++;
      prevSel = bus.o_select;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return one << d;
  endfunction

  // Waits until more than k drives were logged, then returns a 3-cycle free pulse.
  task automatic serve_one(input int k, output bit ok);
    for (int i = 0; i < 40 && drvQ.size() <= k; i++) tick();
    ok = (drvQ.size() > k);
    if (ok) begin
      bus.i_free = 1'b1;
      repeat (3) tick();
      bus.i_free = 1'b0;
    end
  endtask

  task automatic test_reset();
    int  n;
    bit  seen;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    testsRun++; if (bus.o_select !== 4'b0000) begin testsFailed++; $display("FAIL rst_select got=%b exp=0000", bus.o_select); end
    testsRun++; if (bus.o_drive !== 1'b0) begin testsFailed++; $display("FAIL rst_drive got=%b exp=0", bus.o_drive); end
    testsRun++; if (bus.in_ready !== 1'b1) begin testsFailed++; $display("FAIL rst_ready got=%b exp=1", bus.in_ready); end
    testsRun++; if (bus.o_busy !== 1'b0) begin testsFailed++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
    testsRun++; if (bus.o_timeout !== 1'b0) begin testsFailed++; $display("FAIL rst_timeout got=%b exp=0", bus.o_timeout); end
    // Put one tag in flight, then reset while it waits for its free.
    bus.in_valid = 1'b1; bus.in_dest = 2'd1;
    tick();
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.o_drive) seen = 1'b1; else tick();
    end
    testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("FAIL rst_pre_drive got=%b exp=1", seen); end
    tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    testsRun++; if (bus.o_select !== 4'b0000) begin testsFailed++; $display("FAIL midrst_select got=%b exp=0000", bus.o_select); end
    testsRun++; if (bus.o_drive !== 1'b0) begin testsFailed++; $display("FAIL midrst_drive got=%b exp=0", bus.o_drive); end
    testsRun++; if (bus.o_busy !== 1'b0) begin testsFailed++; $display("FAIL midrst_busy got=%b exp=0", bus.o_busy); end
    testsRun++; if (bus.in_ready !== 1'b1) begin testsFailed++; $display("FAIL midrst_ready got=%b exp=1", bus.in_ready); end
    n = drvQ.size();
    bus.i_free = 1'b1;
    repeat (3) tick();
    bus.i_free = 1'b0;
    repeat (8) tick();
    testsRun++; if (drvQ.size() !== n) begin testsFailed++; $display("FAIL midrst_no_drive got=%0d exp=%0d", drvQ.size(), n); end
    testsRun++; if (bus.o_select !== 4'b0000) begin testsFailed++; $display("FAIL midrst_idle_select got=%b exp=0000", bus.o_select); end
  endtask

  task automatic test_single();
    drvQ.delete();
    testsRun++; if (bus.in_ready !== 1'b1) begin testsFailed++; $display("FAIL single_ready got=%b exp=1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_dest = 2'd2;          // cycle 0
    tick();                                           // cycle 1
    bus.in_valid = 1'b0;
    testsRun++; if (bus.o_select !== 4'b0000) begin testsFailed++; $display("FAIL single_c1_select got=%b exp=0000", bus.o_select); end
    tick();                                           // cycle 2
    testsRun++; if (bus.o_select !== 4'b0100) begin testsFailed++; $display("FAIL single_c2_select got=%b exp=0100", bus.o_select); end
    testsRun++; if (bus.o_drive !== 1'b0) begin testsFailed++; $display("FAIL single_c2_drive got=%b exp=0", bus.o_drive); end
    tick();                                           // cycle 3
    testsRun++; if (bus.o_drive !== 1'b1) begin testsFailed++; $display("FAIL single_c3_drive got=%b exp=1", bus.o_drive); end
    testsRun++; if (bus.o_select !== 4'b0100) begin testsFailed++; $display("FAIL single_c3_select got=%b exp=0100", bus.o_select); end
    tick();                                           // cycle 4
    testsRun++; if (bus.o_drive !== 1'b0) begin testsFailed++; $display("FAIL single_c4_drive got=%b exp=0", bus.o_drive); end
    bus.i_free = 1'b1;
    repeat (2) tick();                                // cycle 6
    testsRun++; if (bus.o_select !== 4'b0100) begin testsFailed++; $display("FAIL single_hold_select got=%b exp=0100", bus.o_select); end
    tick();                                           // cycle 7 = free + SYNC_STAGES + 1
    bus.i_free = 1'b0;
    testsRun++; if (bus.o_select !== 4'b0000) begin testsFailed++; $display("FAIL single_release_select got=%b exp=0000", bus.o_select); end
    testsRun++; if (bus.o_busy !== 1'b0) begin testsFailed++; $display("FAIL single_busy got=%b exp=0", bus.o_busy); end
    testsRun++; if (drvQ.size() !== 1) begin testsFailed++; $display("FAIL single_drive_count got=%0d exp=1", drvQ.size()); end
  endtask

  task automatic test_back_to_back();
    int         tags[4] = '{0, 1, 3, 2};
    bit         ok;
    logic [3:0] got;
    drvQ.delete();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_dest = 2'(tags[i]);
      testsRun++; if (bus.in_ready !== 1'b1) begin testsFailed++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve_one(i, ok);
      testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("FAIL b2b_wait_drive[%0d] got=%b exp=1", i, ok); end
    end
    repeat (6) tick();
    testsRun++; if (drvQ.size() !== 4) begin testsFailed++; $display("FAIL b2b_drive_count got=%0d exp=4", drvQ.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < drvQ.size()) ? drvQ[i] : 4'bxxxx;
      testsRun++; if (got !== oh(tags[i])) begin testsFailed++; $display("FAIL b2b_order[%0d] got=%b exp=%b", i, got, oh(tags[i])); end
    end
    testsRun++; if (bus.o_busy !== 1'b0) begin testsFailed++; $display("FAIL b2b_busy got=%b exp=0", bus.o_busy); end
  endtask

  task automatic test_full_simul();
    int         tags[6] = '{0, 3, 1, 2, 0, 3};
    int         idx;
    bit         acc;
    bit         ok;
    logic [3:0] got;
    drvQ.delete();
    idx = 0;
    bus.in_valid = 1'b1; bus.in_dest = 2'(tags[0]);
    // Offer tags continuously; the first one stays in flight until its free at cycle 5.
    for (int c = 0; c < 30 && idx < 6; c++) begin
      acc = bus.in_ready;
      if (c == 5) begin
        testsRun++; if (bus.in_ready !== 1'b0) begin testsFailed++; $display("FAIL full_ready_c5 got=%b exp=0", bus.in_ready); end
      end
      if (c == 8) begin
        testsRun++; if (bus.in_ready !== 1'b0) begin testsFailed++; $display("FAIL full_pop_cycle_ready got=%b exp=0", bus.in_ready); end
        testsRun++; if (bus.o_select !== 4'b0000) begin testsFailed++; $display("FAIL full_idle_select got=%b exp=0000", bus.o_select); end
      end
      if (c == 9) begin
        testsRun++; if (bus.in_ready !== 1'b1) begin testsFailed++; $display("FAIL full_after_pop_ready got=%b exp=1", bus.in_ready); end
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 6) bus.in_dest = 2'(tags[idx]); else bus.in_valid = 1'b0;
      end
      if (c == 4) bus.i_free = 1'b1;
      if (c == 7) bus.i_free = 1'b0;
    end
    bus.in_valid = 1'b0;
    testsRun++; if (idx !== 6) begin testsFailed++; $display("FAIL full_accepted got=%0d exp=6", idx); end
    testsRun++; if (bus.in_ready !== 1'b0) begin testsFailed++; $display("FAIL full_refilled_ready got=%b exp=0", bus.in_ready); end
    for (int k = 1; k < 6; k++) begin
      serve_one(k, ok);
      testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("FAIL full_wait_drive[%0d] got=%b exp=1", k, ok); end
    end
    repeat (6) tick();
    testsRun++; if (drvQ.size() !== 6) begin testsFailed++; $display("FAIL full_drive_count got=%0d exp=6", drvQ.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < drvQ.size()) ? drvQ[i] : 4'bxxxx;
      testsRun++; if (got !== oh(tags[i])) begin testsFailed++; $display("FAIL full_order[%0d] got=%b exp=%b", i, got, oh(tags[i])); end
    end
  endtask

  task automatic test_timeout();
    bit         seen;
    logic [3:0] got;
    drvQ.delete();
    bus.in_valid = 1'b1; bus.in_dest = 2'd1;
    tick();
    bus.in_dest = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.o_drive) seen = 1'b1; else tick();
    end
    testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("FAIL to_first_drive got=%b exp=1", seen); end
    // Drive cycle D; WAIT_FREE spans D+1..D+8 (counter 0..7), flag visible at D+9.
    for (int k = 1; k <= 21; k++) begin
      tick();
      case (k)
        8: begin
          testsRun++; if (bus.o_timeout !== 1'b0) begin testsFailed++; $display("FAIL to_early got=%b exp=0", bus.o_timeout); end
          testsRun++; if (bus.o_select !== 4'b0010) begin testsFailed++; $display("FAIL to_hold_select got=%b exp=0010", bus.o_select); end
        end
        9: begin
          testsRun++; if (bus.o_timeout !== 1'b1) begin testsFailed++; $display("FAIL to_set got=%b exp=1", bus.o_timeout); end
          testsRun++; if (bus.o_select !== 4'b0000) begin testsFailed++; $display("FAIL to_drop_select got=%b exp=0000", bus.o_select); end
          bus.i_free = 1'b1;
        end
        11: begin
          testsRun++; if (bus.o_drive !== 1'b1) begin testsFailed++; $display("FAIL to_next_drive got=%b exp=1", bus.o_drive); end
          testsRun++; if (bus.o_select !== 4'b1000) begin testsFailed++; $display("FAIL to_next_select got=%b exp=1000", bus.o_select); end
        end
        12: bus.i_free = 1'b0;
        13: begin
          testsRun++; if (bus.o_select !== 4'b1000) begin testsFailed++; $display("FAIL to_late_free_ignored got=%b exp=1000", bus.o_select); end
          testsRun++; if (bus.o_timeout !== 1'b1) begin testsFailed++; $display("FAIL to_sticky got=%b exp=1", bus.o_timeout); end
        end
        14: bus.i_clr_timeout = 1'b1;
        15: begin
          bus.i_clr_timeout = 1'b0;
          testsRun++; if (bus.o_timeout !== 1'b0) begin testsFailed++; $display("FAIL to_clear got=%b exp=0", bus.o_timeout); end
        end
        19: bus.i_clr_timeout = 1'b1;
        20: begin
          testsRun++; if (bus.o_timeout !== 1'b1) begin testsFailed++; $display("FAIL to_set_wins got=%b exp=1", bus.o_timeout); end
        end
        21: begin
          bus.i_clr_timeout = 1'b0;
          testsRun++; if (bus.o_timeout !== 1'b0) begin testsFailed++; $display("FAIL to_clear2 got=%b exp=0", bus.o_timeout); end
          testsRun++; if (bus.o_busy !== 1'b0) begin testsFailed++; $display("FAIL to_busy got=%b exp=0", bus.o_busy); end
        end
        default: ;
      endcase
    end
    testsRun++; if (drvQ.size() !== 2) begin testsFailed++; $display("FAIL to_drive_count got=%0d exp=2", drvQ.size()); end
    got = (drvQ.size() > 1) ? drvQ[1] : 4'bxxxx;
    testsRun++; if (got !== 4'b1000) begin testsFailed++; $display("FAIL to_second_tag got=%b exp=1000", got); end
  endtask

  task automatic test_random();
    logic [3:0] expQ[$];
    int         sent;
    int         cyc;
    int         freeWait;
    int         freeHigh;
    int         badIdx;
    drvQ.delete();
    sent = 0; cyc = 0; freeWait = -1; freeHigh = 0;
    // Free delay kept to 0..4 cycles so every free beats the 8-cycle timeout.
    while ((sent < NUM_RANDOM || drvQ.size() < sent || bus.o_busy) && cyc < 30000) begin
      if (freeHigh > 0) begin
        freeHigh--;
        if (freeHigh == 0) bus.i_free = 1'b0;
      end
      if (bus.o_drive) freeWait = int'($urandom_range(0, 4));
      if (freeWait == 0) begin
        bus.i_free = 1'b1; freeHigh = 2; freeWait = -1;
      end else if (freeWait > 0) begin
        freeWait--;
      end
      if (sent < NUM_RANDOM && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1; bus.in_dest = 2'($urandom_range(0, 3));
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(oh(int'(bus.in_dest)));
        sent++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.i_free   = 1'b0;
    repeat (4) tick();
    testsRun++; if (cyc >= 30000) begin testsFailed++; $display("FAIL rnd_budget got=%0d exp<30000", cyc); end
    testsRun++; if (sent !== NUM_RANDOM) begin testsFailed++; $display("FAIL rnd_sent got=%0d exp=%0d", sent, NUM_RANDOM); end
    testsRun++; if (drvQ.size() !== expQ.size()) begin testsFailed++; $display("FAIL rnd_count got=%0d exp=%0d", drvQ.size(), expQ.size()); end
    badIdx = -1;
    for (int i = 0; i < expQ.size() && i < drvQ.size(); i++) begin
      if (badIdx < 0 && drvQ[i] !== expQ[i]) badIdx = i;
    end
    testsRun++; if (badIdx !== -1) begin testsFailed++; $display("FAIL rnd_order first_bad_index got=%0d exp=-1", badIdx); end
    testsRun++; if (oneHotErr !== 0) begin testsFailed++; $display("FAIL onehot_invariant got=%0d exp=0", oneHotErr); end
    testsRun++; if (stabErr !== 0) begin testsFailed++; $display("FAIL select_stable got=%0d exp=0", stabErr); end
    testsRun++; if (bus.o_timeout !== 1'b0) begin testsFailed++; $display("FAIL rnd_timeout got=%b exp=0", bus.o_timeout); end
  endtask

  initial begin
    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_dest       = 2'd0;
    bus.i_free        = 1'b0;
    bus.i_clr_timeout = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_simul();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
